// File: rtl/reset_source_if.sv
// reset_source_if
//   Bundles the reset-request front end's control inputs and status outputs.
//   master : the driver side (software/board model). It drives the requests
//            and watchdog configuration and observes the outputs.
//   slave  : reset_source itself.
//   Signals:
//     btn_n       raw asynchronous push button, active-low
//     sw_rst_req  software reset request, single-cycle pulse
//     wdt_en      watchdog enable (level)
//     wdt_kick    watchdog reload pulse
//     wdt_timeout watchdog reload value
//     cause_clr   clears rst_cause (pulse)
//     rst_req_n   registered active-low reset request
//     rst_cause   sticky cause bits {wdt, sw, btn, por}
//     wdt_count   current watchdog count
interface reset_source_if #(
  parameter int WDT_WIDTH = 24
);
  logic                 btn_n;
  logic                 sw_rst_req;
  logic                 wdt_en;
  logic                 wdt_kick;
  logic [WDT_WIDTH-1:0] wdt_timeout;
  logic                 cause_clr;
  logic                 rst_req_n;
  logic [3:0]           rst_cause;
  logic [WDT_WIDTH-1:0] wdt_count;

  modport master (
    output btn_n, sw_rst_req, wdt_en, wdt_kick, wdt_timeout, cause_clr,
    input  rst_req_n, rst_cause, wdt_count
  );

  modport slave (
    input  btn_n, sw_rst_req, wdt_en, wdt_kick, wdt_timeout, cause_clr,
    output rst_req_n, rst_cause, wdt_count
  );
endinterface

// File: rtl/reset_source.sv
// reset_source
//   Merges power-on, debounced push button, watchdog expiry and software
//   requests into one registered active-low reset request with a minimum
//   low width, and keeps a sticky record of what caused each reset.
//   This block is reset only by power-on (rst_in), so the cause register and
//   the watchdog configuration survive the core resets it generates.
//   Ports:
//     clk    system clock
//     rst_in asynchronous active-low power-on reset
//     bus    reset_source_if.slave (requests in, rst_req_n/rst_cause/wdt_count out)
module reset_source #(
  parameter int DEBOUNCE_CNT = 50000,
  parameter int PULSE_CNT    = 16,
  parameter int WDT_WIDTH    = 24
) (
  input  logic         clk,
  input  logic         rst_in,
  reset_source_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int PC_W = (PULSE_CNT > 1) ? $clog2(PULSE_CNT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CNT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  // Button path
  logic            btn_meta_reg;
  logic            btn_s_reg;
  logic            btn_state_reg;
  logic            btn_state_d_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            btn_evt;

  // Watchdog
  logic [WDT_WIDTH-1:0] wdt_count_reg;
  logic                 wdt_evt;
  logic                 wdt_reload;

  // Sequencer
  state_t          state_reg;
  logic [PC_W-1:0] pcnt_reg;
  logic            rst_req_n_reg;
  logic            trig;

  logic [3:0]      cause_reg;

  // Two-flop synchronizer; idles high (button released).
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      btn_meta_reg <= 1'b1;
      btn_s_reg    <= 1'b1;
    end else begin
      btn_meta_reg <= bus.btn_n;
      btn_s_reg    <= btn_meta_reg;
    end
  end

  // A new level is accepted only after DEBOUNCE_CNT consecutive differing
  // samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      btn_state_reg   <= 1'b1;
      btn_state_d_reg <= 1'b1;
      db_cnt_reg      <= '0;
    end else begin
      btn_state_d_reg <= btn_state_reg;
      if (btn_s_reg == btn_state_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        btn_state_reg <= btn_s_reg;
        db_cnt_reg    <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  // Press event: debounced level has just gone from released to pressed.
  assign btn_evt = btn_state_d_reg & ~btn_state_reg;

  // The count is held at the reload value while disabled, kicked, or while
  // the reset pulse is active, so a kick always beats an expiry.
  assign wdt_reload = ~bus.wdt_en | bus.wdt_kick | (state_reg == PULSE);
  assign wdt_evt    = ~wdt_reload & (wdt_count_reg == '0);

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wdt_count_reg <= '0;
    end else if (wdt_reload || wdt_evt) begin
      wdt_count_reg <= bus.wdt_timeout;
    end else begin
      wdt_count_reg <= wdt_count_reg - 1'b1;
    end
  end

  assign trig = btn_evt | wdt_evt | bus.sw_rst_req;

  // Pulse sequencer. Triggers seen during PULSE are ignored here; the pulse
  // is only stretched while the debounced button is still held.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= PULSE;
      pcnt_reg      <= PC_LAST;
      rst_req_n_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          rst_req_n_reg <= 1'b1;
          if (trig) begin
            state_reg     <= PULSE;
            pcnt_reg      <= PC_LAST;
            rst_req_n_reg <= 1'b0;
          end
        end
        PULSE: begin
          rst_req_n_reg <= 1'b0;
          if (pcnt_reg != '0) begin
            pcnt_reg <= pcnt_reg - 1'b1;
          end else if (btn_state_reg) begin
            state_reg     <= IDLE;
            rst_req_n_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= PULSE;
          pcnt_reg      <= PC_LAST;
          rst_req_n_reg <= 1'b0;
        end
      endcase
    end
  end

  // Sticky causes; a set in the same cycle as a clear wins. Bit 0 (por) is
  // only ever set by rst_in.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cause_reg <= 4'b0001;
    end else begin
      cause_reg <= (bus.cause_clr ? 4'b0000 : cause_reg)
                 | {wdt_evt, bus.sw_rst_req, btn_evt, 1'b0};
    end
  end

  assign bus.rst_req_n = rst_req_n_reg;
  assign bus.rst_cause = cause_reg;
  assign bus.wdt_count = wdt_count_reg;

endmodule

// File: tb/tb_reset_source.sv
// tb_reset_source
//   Directed bench for reset_source with DEBOUNCE_CNT=4, PULSE_CNT=8,
//   WDT_WIDTH=8. Inputs are driven 1 ns after a rising edge and outputs are
//   sampled at the same point, so each sample reflects the last edge.
module tb_reset_source;
  localparam int WW = 8;

  logic clk;
  logic rst_in;
  int   n_cmp;
  int   n_bad;

  reset_source_if #(.WDT_WIDTH(WW)) bus ();

  reset_source #(
    .DEBOUNCE_CNT(4),
    .PULSE_CNT   (8),
    .WDT_WIDTH   (WW)
  ) dut (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts sample points with rst_req_n low, starting at the current one.
  task automatic measure_low(output int n);
    n = 0;
    while (bus.rst_req_n === 1'b0 && n < 200) begin
      n++;
      step();
    end
  endtask

  // Counts steps until rst_req_n goes low (bounded).
  task automatic wait_fall(output int k);
    k = 0;
    while (bus.rst_req_n === 1'b1 && k < 200) begin
      step();
      k++;
    end
  endtask

  task automatic clear_cause();
    bus.cause_clr = 1'b1;
    step();
    bus.cause_clr = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit ok;
    rst_in = 1'b0;
    #1;
    n_cmp++;
    if (bus.rst_req_n !== 1'b0) begin
      n_bad++; $display("FAIL por_async rst_req_n=%b want 0", bus.rst_req_n);
    end
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.rst_req_n !== 1'b0) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL por_held rst_req_n went high while rst_in low");
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0001) begin
      n_bad++; $display("FAIL por_cause_in_reset rst_cause=%b want 0001", bus.rst_cause);
    end
    n_cmp++;
    if (bus.wdt_count !== 8'd0) begin
      n_bad++; $display("FAIL por_wdt_count wdt_count=%0d want 0", bus.wdt_count);
    end
    rst_in = 1'b1;
    measure_low(n);
    n_cmp++;
    if (n != 8) begin
      n_bad++; $display("FAIL por_pulse_len low=%0d want 8", n);
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0001) begin
      n_bad++; $display("FAIL por_cause rst_cause=%b want 0001", bus.rst_cause);
    end
    $display("power-on: low %0d cycles after release, cause=%b", n, bus.rst_cause);
  endtask

  task automatic test_sw();
    int n;
    step();
    bus.sw_rst_req = 1'b1;
    n_cmp++;
    if (bus.rst_req_n !== 1'b1) begin
      n_bad++; $display("FAIL sw_idle rst_req_n=%b want 1", bus.rst_req_n);
    end
    step();
    bus.sw_rst_req = 1'b0;
    n_cmp++;
    if (bus.rst_req_n !== 1'b0) begin
      n_bad++; $display("FAIL sw_latency rst_req_n=%b want 0", bus.rst_req_n);
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0101) begin
      n_bad++; $display("FAIL sw_cause rst_cause=%b want 0101", bus.rst_cause);
    end
    measure_low(n);
    n_cmp++;
    if (n != 8) begin
      n_bad++; $display("FAIL sw_pulse_len low=%0d want 8", n);
    end
    $display("sw request: low %0d cycles, cause=%b", n, bus.rst_cause);
  endtask

  task automatic test_cause_clr();
    clear_cause();
    n_cmp++;
    if (bus.rst_cause !== 4'b0000) begin
      n_bad++; $display("FAIL cause_clr rst_cause=%b want 0000", bus.rst_cause);
    end
    $display("cause clear: cause=%b", bus.rst_cause);
  endtask

  task automatic test_button();
    int k;
    int low;
    int cyc;
    bit ok;
    // Glitch of 3 cycles must be rejected.
    bus.btn_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.btn_n = 1'b1;
    ok = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.rst_req_n !== 1'b1) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL btn_glitch rst_req_n pulsed on a 3-cycle glitch");
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0000) begin
      n_bad++; $display("FAIL btn_glitch_cause rst_cause=%b want 0000", bus.rst_cause);
    end
    $display("button glitch: no reset, cause=%b", bus.rst_cause);
    // Real press, held 20 cycles.
    bus.btn_n = 1'b0;
    wait_fall(k);
    n_cmp++;
    if (k != 7) begin
      n_bad++; $display("FAIL btn_latency cycles=%0d want 7", k);
    end
    cyc = k;
    low = 0;
    while (bus.rst_req_n === 1'b0 && low < 100) begin
      low++;
      if (cyc == 20) bus.btn_n = 1'b1;
      step();
      cyc++;
    end
    bus.btn_n = 1'b1;
    // Released after 20 cycles -> 2 sync + 4 debounce + 1 exit edge later.
    n_cmp++;
    if (low != 20) begin
      n_bad++; $display("FAIL btn_pulse_len low=%0d want 20", low);
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0010) begin
      n_bad++; $display("FAIL btn_cause rst_cause=%b want 0010", bus.rst_cause);
    end
    $display("button press: fall after %0d, low %0d, cause=%b", k, low, bus.rst_cause);
  endtask

  task automatic test_watchdog();
    int k;
    int n;
    clear_cause();
    bus.wdt_timeout = 8'd5;
    step();
    n_cmp++;
    if (bus.wdt_count !== 8'd5) begin
      n_bad++; $display("FAIL wdt_reload wdt_count=%0d want 5", bus.wdt_count);
    end
    bus.wdt_en = 1'b1;
    wait_fall(k);
    n_cmp++;
    if (k != 6) begin
      n_bad++; $display("FAIL wdt_latency cycles=%0d want 6", k);
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b1000) begin
      n_bad++; $display("FAIL wdt_cause rst_cause=%b want 1000", bus.rst_cause);
    end
    measure_low(n);
    n_cmp++;
    if (n != 8) begin
      n_bad++; $display("FAIL wdt_pulse_len low=%0d want 8", n);
    end
    n_cmp++;
    if (bus.wdt_count !== 8'd5) begin
      n_bad++; $display("FAIL wdt_held_in_pulse wdt_count=%0d want 5", bus.wdt_count);
    end
    $display("watchdog: fire after %0d, low %0d, cause=%b", k, n, bus.rst_cause);
  endtask

  task automatic test_kick();
    bit ok;
    ok = 1;
    for (int i = 0; i < 200; i++) begin
      bus.wdt_kick = (i % 4 == 0);
      step();
      if (bus.rst_req_n !== 1'b1) ok = 0;
    end
    bus.wdt_kick = 1'b0;
    bus.wdt_en   = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL wdt_kick reset occurred despite kicks");
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b1000) begin
      n_bad++; $display("FAIL wdt_kick_cause rst_cause=%b want 1000", bus.rst_cause);
    end
    step();
    $display("watchdog kicks: 200 cycles, cause=%b", bus.rst_cause);
  endtask

  task automatic test_simultaneous();
    int low;
    // Set and clear in the same cycle: set wins, old bits drop.
    bus.sw_rst_req = 1'b1;
    bus.cause_clr  = 1'b1;
    step();
    bus.sw_rst_req = 1'b0;
    bus.cause_clr  = 1'b0;
    n_cmp++;
    if (bus.rst_cause !== 4'b0100) begin
      n_bad++; $display("FAIL set_beats_clr rst_cause=%b want 0100", bus.rst_cause);
    end
    measure_low(low);
    n_cmp++;
    if (low != 8) begin
      n_bad++; $display("FAIL set_clr_pulse_len low=%0d want 8", low);
    end
    $display("sw+clear: cause=%b low %0d", bus.rst_cause, low);
    // Trigger in the 3rd cycle of a pulse: recorded, pulse not extended.
    step();
    bus.sw_rst_req = 1'b1;
    step();
    bus.sw_rst_req = 1'b0;
    low = 0;
    while (bus.rst_req_n === 1'b0 && low < 100) begin
      low++;
      bus.cause_clr  = (low == 2);
      bus.sw_rst_req = (low == 3);
      step();
    end
    bus.cause_clr  = 1'b0;
    bus.sw_rst_req = 1'b0;
    n_cmp++;
    if (low != 8) begin
      n_bad++; $display("FAIL mid_pulse_len low=%0d want 8", low);
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0100) begin
      n_bad++; $display("FAIL mid_pulse_cause rst_cause=%b want 0100", bus.rst_cause);
    end
    $display("sw in pulse: low %0d, cause=%b", low, bus.rst_cause);
  endtask

  task automatic test_reset_mid_pulse();
    int k;
    int low;
    bus.wdt_timeout = 8'd5;
    bus.wdt_en      = 1'b1;
    wait_fall(k);
    n_cmp++;
    if (k != 6) begin
      n_bad++; $display("FAIL rmp_wdt_latency cycles=%0d want 6", k);
    end
    step();
    step();
    rst_in = 1'b0;
    #1;
    n_cmp++;
    if (bus.rst_req_n !== 1'b0) begin
      n_bad++; $display("FAIL rmp_req rst_req_n=%b want 0", bus.rst_req_n);
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0001) begin
      n_bad++; $display("FAIL rmp_cause rst_cause=%b want 0001", bus.rst_cause);
    end
    n_cmp++;
    if (bus.wdt_count !== 8'd0) begin
      n_bad++; $display("FAIL rmp_wdt_count wdt_count=%0d want 0", bus.wdt_count);
    end
    step();
    step();
    rst_in = 1'b1;
    measure_low(low);
    bus.wdt_en = 1'b0;
    n_cmp++;
    if (low != 8) begin
      n_bad++; $display("FAIL rmp_pulse_len low=%0d want 8", low);
    end
    n_cmp++;
    if (bus.rst_cause !== 4'b0001) begin
      n_bad++; $display("FAIL rmp_cause_after rst_cause=%b want 0001", bus.rst_cause);
    end
    $display("reset mid-pulse: low %0d after release, cause=%b", low, bus.rst_cause);
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    rst_in          = 1'b0;
    bus.btn_n       = 1'b1;
    bus.sw_rst_req  = 1'b0;
    bus.wdt_en      = 1'b0;
    bus.wdt_kick    = 1'b0;
    bus.wdt_timeout = 8'd0;
    bus.cause_clr   = 1'b0;
    test_reset();
    test_sw();
    test_cause_clr();
    test_button();
    test_watchdog();
    test_kick();
    test_simultaneous();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
